// File: rtl/averager_pkg.sv
// Shared definitions for the moving averager.
// Provides the mode encodings seen on the mode input and the window-state enum.
package averager_pkg;

  localparam logic MODE_SLIDING = 1'b0;
  localparam logic MODE_BLOCK   = 1'b1;

  typedef enum logic {
    S_FILL   = 1'b0,
    S_STEADY = 1'b1
  } state_t;

endpackage

// File: rtl/avg_ring_buffer.sv
// Circular sample store for the moving averager.
// Ports:
//   clk   - rising-edge clock
//   we    - write enable, stores wdata at addr on the edge
//   addr  - shared read/write address (the averager's write pointer)
//   wdata - sample to store
//   rdata - current contents at addr, i.e. the value before this edge's write
// Storage is not reset; the averager never consumes an entry before it has
// been written since the last flush.
module avg_ring_buffer #(
  parameter int WIDTH      = 12,
  parameter int LOG2_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [LOG2_DEPTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);

  localparam int DEPTH = 2 ** LOG2_DEPTH;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read is combinational so the evicted sample is available in the same
  // cycle as the write that replaces it.
  assign rdata = mem[addr];

endmodule

// File: rtl/moving_averager.sv
// Moving / block averager over a window of 2**LOG2_DEPTH unsigned samples.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_FILL   | fewer than DEPTH samples accumulated since the last flush
// S_STEADY | window full (sliding mode only); each sample evicts the oldest
//
// Ports:
//   clk     - sole clock, rising edge
//   reset   - synchronous active-high reset, overrides everything
//   EN      - Din accepted on an edge where EN=1
//   Din     - unsigned sample
//   mode    - 0 sliding window, 1 decimating block average
//   clear   - synchronous flush of window state (Q held)
//   Q       - registered average, floor(sum / DEPTH)
//   q_valid - one-cycle pulse marking a new Q
//   full    - window holds DEPTH samples (block mode: pulses with q_valid)
module moving_averager
  import averager_pkg::*;
#(
  parameter int WIDTH      = 12,
  parameter int LOG2_DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             EN,
  input  logic [WIDTH-1:0] Din,
  input  logic             mode,
  input  logic             clear,
  output logic [WIDTH-1:0] Q,
  output logic             q_valid,
  output logic             full
);

  localparam int DEPTH = 2 ** LOG2_DEPTH;
  localparam int ACC_W = WIDTH + LOG2_DEPTH;

  state_t                state_q, state_d;
  logic [ACC_W-1:0]      sum_q, sum_d;
  logic [LOG2_DEPTH:0]   count_q, count_d;
  logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [WIDTH-1:0]      q_q, q_d;
  logic                  q_valid_q, q_valid_d;
  logic                  mode_q, mode_d;

  logic [WIDTH-1:0]      oldest;
  logic                  flush;
  logic                  accept;
  logic                  last_fill;
  logic [ACC_W-1:0]      sum_fill;
  logic [ACC_W-1:0]      sum_slide;

  // A mode change mid-stream mixes incompatible window semantics, so it
  // flushes exactly like clear.
  assign flush  = clear | (mode != mode_q);
  assign accept = EN & ~flush;

  assign last_fill = (count_q == (LOG2_DEPTH + 1)'(DEPTH - 1));
  assign sum_fill  = sum_q + ACC_W'(Din);
  // oldest is always part of sum_q, so subtracting first cannot underflow
  // and the result never exceeds DEPTH * max sample.
  assign sum_slide = sum_q - ACC_W'(oldest) + ACC_W'(Din);

  avg_ring_buffer #(
    .WIDTH      (WIDTH),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_ring (
    .clk   (clk),
    .we    (accept & ~reset),
    .addr  (wr_ptr_q),
    .wdata (Din),
    .rdata (oldest)
  );

  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    q_d       = q_q;
    q_valid_d = 1'b0;
    mode_d    = mode;

    if (flush) begin
      state_d  = S_FILL;
      sum_d    = '0;
      count_d  = '0;
      wr_ptr_d = '0;
    end else if (EN) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      unique case (state_q)
        S_FILL: begin
          if (last_fill) begin
            q_d       = sum_fill[ACC_W-1:LOG2_DEPTH];
            q_valid_d = 1'b1;
            if (mode_q == MODE_BLOCK) begin
              sum_d   = '0;
              count_d = '0;
            end else begin
              sum_d   = sum_fill;
              count_d = count_q + 1'b1;
              state_d = S_STEADY;
            end
          end else begin
            sum_d   = sum_fill;
            count_d = count_q + 1'b1;
          end
        end
        S_STEADY: begin
          sum_d     = sum_slide;
          q_d       = sum_slide[ACC_W-1:LOG2_DEPTH];
          q_valid_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FILL;
      sum_q     <= '0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      mode_q    <= mode;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      mode_q    <= mode_d;
    end
  end

  assign Q       = q_q;
  assign q_valid = q_valid_q;
  // Block mode never dwells in S_STEADY, so full marks the completed block.
  assign full    = (state_q == S_STEADY) | ((mode_q == MODE_BLOCK) & q_valid_q);

endmodule

// File: tb/tb_moving_averager.sv
// Self-checking bench for moving_averager: a default-size instance and a
// LOG2_DEPTH=2 instance, exercised one at a time (the idle one held in reset),
// checked every cycle against a queue-based window model.
module tb_moving_averager;

  localparam int W = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_cmd, sel, en, mode, clear;
  logic [W-1:0] din;
  logic         reset_big, reset_small;
  logic [W-1:0] q_b, q_s;
  logic         qv_b, qv_s, full_b, full_s;

  assign reset_big   = rst_cmd | sel;
  assign reset_small = rst_cmd | ~sel;

  moving_averager u_big (
    .clk(clk), .reset(reset_big), .EN(en), .Din(din), .mode(mode),
    .clear(clear), .Q(q_b), .q_valid(qv_b), .full(full_b)
  );

  moving_averager #(.WIDTH(W), .LOG2_DEPTH(2)) u_small (
    .clk(clk), .reset(reset_small), .EN(en), .Din(din), .mode(mode),
    .clear(clear), .Q(q_s), .q_valid(qv_s), .full(full_s)
  );

  int errors = 0;
  int checks = 0;

  // reference model state
  int win[$];
  bit mode_m;
  int q_m;
  bit qv_m;
  int lg;
  int pulses;
  int seen[$];

  function automatic logic [W-1:0] q_act();
    return sel ? q_s : q_b;
  endfunction
  function automatic logic qv_act();
    return sel ? qv_s : qv_b;
  endfunction
  function automatic logic full_act();
    return sel ? full_s : full_b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit e, input int d, input bit c, input bit m);
    int depth;
    int s;
    depth = 1 << lg;
    qv_m  = 1'b0;
    if (r) begin
      win.delete();
      q_m    = 0;
      mode_m = m;
    end else if (c || (m != mode_m)) begin
      win.delete();
      mode_m = m;
    end else if (e) begin
      win.push_back(d);
      if (win.size() > depth) void'(win.pop_front());
      if (win.size() == depth) begin
        s = 0;
        foreach (win[i]) s += win[i];
        q_m  = s / depth;
        qv_m = 1'b1;
        if (mode_m) win.delete();
      end
    end
  endtask

  task automatic step(input bit r, input bit e, input int d, input bit c, input bit m,
                      input string tag);
    bit exp_full;
    rst_cmd = r;
    en      = e;
    din     = d[W-1:0];
    clear   = c;
    mode    = m;
    @(posedge clk);
    #1;
    model_step(r, e, d, c, m);
    if (qv_m) pulses++;
    if (qv_act() === 1'b1) seen.push_back(int'(q_act()));
    exp_full = mode_m ? qv_m : (win.size() == (1 << lg));
    check({tag, ".q"},       32'(q_act()),    32'(q_m));
    check({tag, ".q_valid"}, 32'(qv_act()),   32'(qv_m));
    check({tag, ".full"},    32'(full_act()), 32'(exp_full));
  endtask

  initial begin
    int stream[12];
    int blk[8];
    int e, c, m;

    sel = 1'b0; rst_cmd = 1'b1; en = 1'b0; din = '0; clear = 1'b0; mode = 1'b0;
    lg = 8; pulses = 0;

    // default instance: reset state
    step(1, 0, 0, 0, 0, "reset");

    // constant 2047 fill: single pulse after the 256th sample
    pulses = 0;
    for (int k = 0; k < 256; k++) step(0, 1, 2047, 0, 0, "fill2047");
    check("fill2047.pulses", 32'(pulses), 32'd1);
    check("fill2047.final_q", 32'(q_b), 32'd2047);
    check("fill2047.final_full", 32'(full_b), 32'd1);

    // window of zeros then 4095s: Q ramps with no wraparound
    step(0, 0, 0, 1, 0, "clr");
    for (int k = 0; k < 256; k++) step(0, 1, 0, 0, 0, "zeros");
    for (int k = 1; k <= 256; k++) begin
      step(0, 1, 4095, 0, 0, "ramp");
      check("ramp.formula", 32'(q_b), 32'((4095 * k) / 256));
    end
    check("ramp.top", 32'(q_b), 32'd4095);

    // random sliding traffic with sparse EN gaps and clears
    for (int k = 0; k < 400; k++) begin
      e = ($urandom_range(0, 3) != 0) ? 1 : 0;
      c = ($urandom_range(0, 60) == 0) ? 1 : 0;
      step(0, e[0], int'($urandom_range(0, 4095)), c[0], 0, "rnd_slide");
    end

    // block mode on the default instance (mode change flushes)
    for (int k = 0; k < 700; k++) begin
      e = ($urandom_range(0, 3) != 0) ? 1 : 0;
      step(0, e[0], int'($urandom_range(0, 4095)), 0, 1, "rnd_block");
    end

    // reset mid-window discards everything, Q returns to 0
    step(0, 0, 0, 0, 0, "to_slide");
    for (int k = 0; k < 100; k++) step(0, 1, 3000, 0, 0, "pre_rst");
    step(1, 0, 0, 0, 0, "mid_rst");
    check("mid_rst.q_zero", 32'(q_b), 32'd0);
    pulses = 0;
    for (int k = 0; k < 255; k++) step(0, 1, 100, 0, 0, "post_rst");
    check("post_rst.no_pulse", 32'(pulses), 32'd0);
    step(0, 1, 100, 0, 0, "post_rst_last");
    check("post_rst.pulse", 32'(pulses), 32'd1);

    // small instance, DEPTH = 4
    sel = 1'b1;
    lg  = 2;

    // block mode: 1,2,3,5 -> 2 ; 4,4,4,4 -> 4
    step(1, 0, 0, 0, 1, "s_rst_blk");
    blk = '{1, 2, 3, 5, 4, 4, 4, 4};
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      step(0, 1, blk[k], 0, 1, "blk");
      if (k == 3) check("blk.first", 32'(q_s), 32'd2);
    end
    check("blk.second", 32'(q_s), 32'd4);
    check("blk.pulses", 32'(pulses), 32'd2);

    // clear beats EN: the 9 is dropped
    step(1, 0, 0, 0, 0, "s_rst_sl");
    step(0, 1, 3, 0, 0, "pre_clr");
    step(0, 1, 6, 0, 0, "pre_clr");
    step(0, 1, 9, 1, 0, "clr9");
    check("clr9.full", 32'(full_s), 32'd0);
    pulses = 0;
    for (int k = 0; k < 3; k++) step(0, 1, 8, 0, 0, "refill8");
    check("refill8.none", 32'(pulses), 32'd0);
    step(0, 1, 8, 0, 0, "refill8_last");
    check("refill8.pulse", 32'(pulses), 32'd1);
    check("refill8.q", 32'(q_s), 32'd8);

    // same stream contiguous vs EN toggling: identical Q sequence
    foreach (stream[i]) stream[i] = int'($urandom_range(0, 4095));
    for (int pass = 0; pass < 2; pass++) begin
      step(1, 0, 0, 0, 0, "s_rst_seq");
      seen.delete();
      for (int k = 0; k < 12; k++) begin
        if (pass == 1) step(0, 0, int'($urandom_range(0, 4095)), 0, 0, "seq_gap");
        step(0, 1, stream[k], 0, 0, "seq");
      end
      check("seq.count", 32'(seen.size()), 32'd9);
      for (int k = 0; k < 9 && k < seen.size(); k++)
        check("seq.value", 32'(seen[k]),
              32'((stream[k] + stream[k+1] + stream[k+2] + stream[k+3]) / 4));
    end

    // mode toggle mid-window flushes; sample on the toggle edge is dropped
    step(1, 0, 0, 0, 0, "s_rst_tog");
    for (int k = 0; k < 3; k++) step(0, 1, 50, 0, 0, "pre_tog");
    step(0, 1, 7, 0, 1, "tog");
    check("tog.full", 32'(full_s), 32'd0);
    pulses = 0;
    for (int k = 0; k < 3; k++) step(0, 1, 20, 0, 1, "post_tog");
    check("post_tog.none", 32'(pulses), 32'd0);
    step(0, 1, 20, 0, 1, "post_tog_last");
    check("post_tog.pulse", 32'(pulses), 32'd1);
    check("post_tog.q", 32'(q_s), 32'd20);

    // random small-window traffic with clears and mode flips
    m = 0;
    for (int k = 0; k < 400; k++) begin
      e = ($urandom_range(0, 2) != 0) ? 1 : 0;
      c = ($urandom_range(0, 30) == 0) ? 1 : 0;
      if ($urandom_range(0, 40) == 0) m = 1 - m;
      step(0, e[0], int'($urandom_range(0, 4095)), c[0], m[0], "rnd_small");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
